// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, registered read data, one-cycle overflow/underflow pulses and synchronous flush.
module fifo_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_n,
  input  logic                     rd_n,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     over_flow,
  output logic                     under_flow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q,  count_d;
  logic [DATA_WIDTH-1:0] dout_q,   dout_d;
  logic                  ovf_q,    ovf_d;
  logic                  udf_q,    udf_d;

  logic rd_ok, wr_ok, wr_en;

  // Flags decode the count register only, so they never glitch.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign fifo_count   = count_q;
  assign data_out     = dout_q;
  assign over_flow    = ovf_q;
  assign under_flow   = udf_q;

  // A full FIFO can still take a write when a read frees a slot on the same edge.
  assign rd_ok = ~rd_n & ~empty;
  assign wr_ok = ~wr_n & (~full | rd_ok);
  assign wr_en = wr_ok & ~clr;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      ovf_d = ~wr_n & ~wr_ok;
      udf_d = ~rd_n & ~rd_ok;
      if (rd_ok) begin
        dout_d   = mem[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (wr_ok && !rd_ok)      count_d = count_q + CW'(1);
      else if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: stimulus pushes the expected post-edge state into a
// scoreboard queue and an independent monitor compares it on the falling edge.
module tb_fifo_param;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_n = 1'b1;
  logic          rd_n = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty, over_flow, under_flow;
  logic [4:0]    fifo_count;

  fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_n(wr_n), .rd_n(rd_n),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .over_flow(over_flow), .under_flow(under_flow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    string      name;
    logic [4:0] cnt;
    logic       ovf;
    logic       udf;
    bit         chk_d;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [10:0] status_act();
    return {fifo_count, full, empty, almost_full, almost_empty, over_flow, under_flow};
  endfunction

  function automatic logic [10:0] status_exp(input logic [4:0] c, input logic o, input logic u);
    return {c, c == 5'(DEPTH), c == 5'd0, c >= 5'(AF), c <= 5'(AE), o, u};
  endfunction

  // Monitor: compare every scoreboard entry whose edge has already happened.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_status"}, 32'(status_act()), 32'(status_exp(e.cnt, e.ovf, e.udf)));
        if (e.chk_d) check({e.name, "_data"}, 32'(data_out), 32'(e.d));
      end
    end
  end

  // Drive one cycle of inputs and record what the FIFO must show after that edge.
  task automatic step(input bit w, input bit r, input logic [7:0] din, input bit c,
                      input string nm, input logic [4:0] ecnt, input logic eovf,
                      input logic eudf, input bit chk_d, input logic [7:0] ed);
    exp_t e;
    wr_n = ~w; rd_n = ~r; data_in = din; clr = c;
    e.tag = cyc + 1; e.name = nm; e.cnt = ecnt; e.ovf = eovf; e.udf = eudf;
    e.chk_d = chk_d; e.d = ed;
    sb.push_back(e);
    @(posedge clk); #1;
    wr_n = 1'b1; rd_n = 1'b1; clr = 1'b0;
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, "_status"}, 32'(status_act()), 32'(status_exp(5'd0, 1'b0, 1'b0)));
    check({nm, "_data"}, 32'(data_out), 32'h0);
  endtask

  initial begin
    // Reset and idle
    #2 check_reset_values("reset");
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 8'h00, 0, "idle", 5'd0, 0, 0, 1, 8'h00);

    // Fill 0x01..0x10, then a rejected 17th write
    for (int i = 1; i <= 16; i++) step(1, 0, 8'(i), 0, "fill", 5'(i), 0, 0, 0, 8'h00);
    step(1, 0, 8'hAA, 0, "overflow", 5'd16, 1, 0, 0, 8'h00);
    step(0, 0, 8'h00, 0, "overflow_end", 5'd16, 0, 0, 0, 8'h00);

    // Drain in order, then a rejected 17th read
    for (int i = 1; i <= 16; i++) step(0, 1, 8'h00, 0, "drain", 5'(16 - i), 0, 0, 1, 8'(i));
    step(0, 1, 8'h00, 0, "underflow", 5'd0, 0, 1, 1, 8'h10);
    step(0, 0, 8'h00, 0, "underflow_end", 5'd0, 0, 0, 1, 8'h10);

    // Read and write together while full
    for (int i = 1; i <= 16; i++) step(1, 0, 8'(8'h20 + i), 0, "refill", 5'(i), 0, 0, 0, 8'h00);
    step(1, 1, 8'h31, 0, "rw_full", 5'd16, 0, 0, 1, 8'h21);
    for (int i = 1; i <= 16; i++) step(0, 1, 8'h00, 0, "drain2", 5'(16 - i), 0, 0, 1, 8'(8'h21 + i));

    // Read and write together while empty: write lands, read rejected
    step(1, 1, 8'h55, 0, "rw_empty", 5'd1, 0, 1, 1, 8'h31);
    step(0, 1, 8'h00, 0, "rw_empty_rd", 5'd0, 0, 0, 1, 8'h55);

    // Streaming with 3 resident entries across pointer wrap
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h60 + i), 0, "preload", 5'(i + 1), 0, 0, 0, 8'h00);
    for (int k = 0; k < 40; k++) step(1, 1, 8'(8'h63 + k), 0, "stream", 5'd3, 0, 0, 1, 8'(8'h60 + k));
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, "stream_tail", 5'(2 - i), 0, 0, 1, 8'(8'h88 + i));

    // Flush at count 9 with a concurrent write
    for (int i = 0; i < 9; i++) step(1, 0, 8'(8'h90 + i), 0, "preflush", 5'(i + 1), 0, 0, 0, 8'h00);
    step(1, 0, 8'hEE, 1, "flush", 5'd0, 0, 0, 1, 8'h8A);
    step(0, 1, 8'h00, 0, "flush_rd", 5'd0, 0, 1, 1, 8'h8A);
    step(1, 0, 8'hA0, 0, "post_flush_wr", 5'd1, 0, 0, 0, 8'h00);
    step(0, 1, 8'h00, 0, "post_flush_rd", 5'd0, 0, 0, 1, 8'hA0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'hB0 + i), 0, "prereset", 5'(i + 1), 0, 0, 0, 8'h00);
    step(1, 1, 8'hB3, 0, "prereset_rw", 5'd3, 0, 0, 1, 8'hB0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 8'h00, 0, "after_reset", 5'd0, 0, 0, 1, 8'h00);
    step(0, 1, 8'h00, 0, "after_reset_rd", 5'd0, 0, 1, 1, 8'h00);

    // Let the monitor catch up, with a bound
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
